// File: rtl/ps2_key_tracker.sv
// PS/2 receiver and single-key make/break tracker feeding the tone decoder.
// Optional: define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
//
// frame state | meaning
// F_IDLE      | waiting for a start bit (falling edge with data 0)
// F_DATA      | shifting in 8 data bits, LSB first
// F_PARITY    | capturing the parity bit
// F_STOP      | checking the stop bit, then publishing or discarding the byte
// key state   | meaning
// K_MAKE      | next byte is a make code
// K_BREAK     | 0xF0 seen, next byte is a released key
module ps2_key_tracker #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_change,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} fstate_t;
  typedef enum logic {K_MAKE, K_BREAK} kstate_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic          clk_filt, fall;
  logic [FW-1:0] filt_cnt;
  fstate_t       fstate;
  kstate_t       kstate;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par, par_ok;
  logic [TW-1:0] to_cnt;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift, par};
`else
  // parity is captured but intentionally never rejects a frame
  assign par_ok = (^{shift, par}) | 1'b1;
`endif

  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hE0, 8'hE1, 8'hEE,
      8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      data_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Down-counter restarts whenever the sample agrees with the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b0;
      filt_cnt <= FW'(FILTER_LEN - 1);
      fall     <= 1'b0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= FW'(FILTER_LEN - 1);
      fall     <= 1'b0;
    end else if (filt_cnt == '0) begin
      clk_filt <= clk_s;
      filt_cnt <= FW'(FILTER_LEN - 1);
      fall     <= ~clk_s;
    end else begin
      filt_cnt <= filt_cnt - 1'b1;
      fall     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate   <= F_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      par      <= 1'b0;
      to_cnt   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (fstate == F_IDLE) begin
        if (fall && !data_s) begin
          fstate  <= F_DATA;
          bit_cnt <= '0;
          to_cnt  <= TW'(TIMEOUT_CYCLES - 1);
        end
      end else if (fall) begin
        // an edge coinciding with expiry wins and restarts the timer
        to_cnt <= TW'(TIMEOUT_CYCLES - 1);
        case (fstate)
          F_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) fstate <= F_PARITY;
          end
          F_PARITY: begin
            par    <= data_s;
            fstate <= F_STOP;
          end
          F_STOP: begin
            if (data_s && par_ok) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            fstate <= F_IDLE;
          end
          default: fstate <= F_IDLE;
        endcase
      end else if (to_cnt == '0) begin
        rx_err <= 1'b1;
        fstate <= F_IDLE;
      end else begin
        to_cnt <= to_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kstate     <= K_MAKE;
      key_code   <= '0;
      key_change <= 1'b0;
    end else begin
      key_change <= 1'b0;
      if (rx_valid && !is_ignored(rx_byte)) begin
        if (rx_byte == 8'hF0) begin
          kstate <= K_BREAK;
        end else if (kstate == K_MAKE) begin
          if (rx_byte != key_code) begin
            key_code   <= rx_byte;
            key_change <= 1'b1;
          end
        end else begin
          if (rx_byte == key_code) begin
            key_code   <= 8'h00;
            key_change <= 1'b1;
          end
          kstate <= K_MAKE;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with a byte-level key-tracking model.
`timescale 1ns/1ps
module tb_ps2_key_tracker;
  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int H  = 25;
`ifdef PS2_PARITY_CHECK_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_change;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_key_tracker #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_change(key_change),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int err_seen = 0, chg_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_key = 8'h00, m_next = 8'h00, m_b;
  bit m_brk = 1'b0, m_pend = 1'b0, m_nchg = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Key rules applied to one accepted byte.
  function automatic void model_byte(input logic [7:0] b);
    m_next = m_key;
    m_nchg = 1'b0;
    if (b inside {8'h00, 8'hAA, 8'hE0, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) return;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin
      m_brk = 1'b0;
      if (b == m_key) begin m_next = 8'h00; m_nchg = 1'b1; end
    end else if (b != m_key) begin
      m_next = b; m_nchg = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {key_code, key_change, rx_byte, rx_valid, rx_err}, 0);
      m_key = 8'h00; m_brk = 1'b0; m_pend = 1'b0;
      exp_q.delete();
    end else begin
      if (m_pend) begin
        chk("key_code_update", key_code, m_next);
        chk("key_change_pulse", key_change, m_nchg);
        m_key = m_next;
        m_pend = 1'b0;
      end else begin
        chk("key_code_hold", key_code, m_key);
        chk("key_change_idle", key_change, 0);
      end
      if (key_change) chg_seen++;
      if (rx_err) err_seen++;
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          chk("rx_valid_unexpected", rx_valid, 0);
        end else begin
          m_b = exp_q.pop_front();
          chk("rx_byte", rx_byte, m_b);
          model_byte(m_b);
          m_pend = 1'b1;
        end
      end
    end
  end

  task automatic bit_out(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out((~^b) ^ bad_par);
    bit_out(~bad_stop);
    ps2_data = 1'b1;
    repeat (4 * H) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_key_code", key_code, 8'h00);
    chk("reset_rx_valid", rx_valid, 0);
    #5 rst_n = 1'b1;
    repeat (50) @(negedge clk);

    send_good(8'h1C);
    chk("make_1c", key_code, 8'h1C);
    chk("make_1c_changes", chg_seen, 1);

    send_good(8'h1C); send_good(8'hF0); send_good(8'h1C);
    chk("repeat_release", key_code, 8'h00);
    chk("repeat_release_changes", chg_seen, 2);

    send_good(8'h1C); send_good(8'h1B); send_good(8'hF0); send_good(8'h1C);
    chk("last_key_wins", key_code, 8'h1B);
    send_good(8'hF0); send_good(8'h1B);
    chk("release_1b", key_code, 8'h00);
    chk("last_key_changes", chg_seen, 5);

    if (PE == 0) exp_q.push_back(8'h23);
    send_frame(8'h23, 1'b1, 1'b0);
    chk("parity_key_code", key_code, (PE != 0) ? 8'h00 : 8'h23);
    chk("parity_err", err_seen, PE);

    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    ps2_data = 1'b1;
    repeat (TO - 200) @(negedge clk);
    chk("timeout_not_early", err_seen, PE);
    repeat (600) @(negedge clk);
    chk("timeout_err", err_seen, PE + 1);
    send_good(8'h23);
    chk("after_timeout", key_code, 8'h23);

    send_good(8'hF0); send_good(8'h23);
    send_good(8'hE0); send_good(8'h75);
    chk("extended_make", key_code, 8'h75);
    send_good(8'hF0); send_good(8'hF0); send_good(8'h75);
    chk("double_f0_release", key_code, 8'h00);

    send_frame(8'h42, 1'b0, 1'b1);
    chk("bad_stop_err", err_seen, PE + 2);
    chk("bad_stop_key", key_code, 8'h00);

    ps2_clk = 1'b0;
    repeat (FL - 4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk);
    bit_out(1'b1);
    ps2_data = 1'b1;
    repeat (4 * H) @(negedge clk);
    chk("glitch_start1_no_err", err_seen, PE + 2);
    send_good(8'h1B);
    chk("make_1b", key_code, 8'h1B);

    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(i == 2 || i == 3);
    ps2_data = 1'b1;
    repeat (H / 2) @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("midframe_reset_key", key_code, 8'h00);
    chk("midframe_reset_byte", rx_byte, 8'h00);
    repeat (3) @(negedge clk);
    #5 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    send_good(8'h2B);
    chk("after_reset_make", key_code, 8'h2B);
    chk("err_total", err_seen, PE + 2);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
